// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core (port 0)
// and the loader/debug port (port 1), one access at a time over the RAM read latency.
module dmem_arbiter #(
    parameter int          RD_LAT = 1,
    parameter logic [31:0] IDLE   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_ce_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        stall_o,

    input  logic        m1_ce_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        gnt;
    logic [2:0]  cnt;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_data;
    logic [31:0] m0_data_q;
    logic [31:0] m1_data_q;
    logic        grant_go;
    logic        grant_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ties go to the port that was not served last, giving strict alternation.
    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        grant_port = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_ce_i || m1_ce_i) begin
                    grant_go   = 1'b1;
                    state_nxt  = ST_BUSY;
                    grant_port = (m0_ce_i && m1_ce_i) ? ~last_grant : m1_ce_i;
                end
            end
            ST_BUSY: begin
                if (cnt == 3'd1) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            cnt        <= 3'd0;
            req_we     <= 1'b0;
            req_addr   <= IDLE;
            req_sel    <= 4'b0000;
            req_data   <= IDLE;
            m0_data_q  <= IDLE;
            m1_data_q  <= IDLE;
        end else begin
            if (grant_go) begin
                last_grant <= grant_port;
                gnt        <= grant_port;
                if (grant_port) begin
                    req_we   <= m1_we_i;
                    req_addr <= m1_addr_i;
                    req_sel  <= m1_sel_i;
                    req_data <= m1_data_i;
                    cnt      <= m1_we_i ? 3'd1 : 3'(RD_LAT);
                end else begin
                    req_we   <= m0_we_i;
                    req_addr <= m0_addr_i;
                    req_sel  <= m0_sel_i;
                    req_data <= m0_data_i;
                    cnt      <= m0_we_i ? 3'd1 : 3'(RD_LAT);
                end
            end else if (state == ST_BUSY) begin
                cnt <= cnt - 3'd1;
                // Last RAM cycle: read data is valid on ram_data_i now.
                if (cnt == 3'd1 && !req_we) begin
                    if (gnt) begin
                        m1_data_q <= ram_data_i;
                    end else begin
                        m0_data_q <= ram_data_i;
                    end
                end
            end
        end
    end

    assign ram_ce_o   = (state == ST_BUSY);
    assign ram_we_o   = (state == ST_BUSY) && req_we;
    assign ram_addr_o = (state == ST_BUSY) ? req_addr : IDLE;
    assign ram_sel_o  = (state == ST_BUSY) ? req_sel : 4'b0000;
    assign ram_data_o = ((state == ST_BUSY) && req_we) ? req_data : IDLE;

    assign m0_ack_o  = (state == ST_ACK) && !gnt;
    assign m1_ack_o  = (state == ST_ACK) && gnt;
    assign m0_data_o = m0_data_q;
    assign m1_data_o = m1_data_q;
    assign stall_o   = m0_ce_i & ~m0_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-timestamp model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        m0_ce_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, stall_o;
    logic        m1_ce_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.RD_LAT(RD_LAT), .IDLE(32'h00000000)) dut (
        .clk(clk), .rst(rst),
        .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .stall_o(stall_o),
        .m1_ce_i(m1_ce_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: read data is only valid in the RD_LAT-th cycle of an access.
    logic [31:0] bench_mem [256];
    int          busy_cnt = 0;

    assign ram_data_i = (ram_ce_o && !ram_we_o && busy_cnt == RD_LAT - 1)
                        ? bench_mem[ram_addr_o[9:2]] : 32'hBAD0BAD0;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else begin
            busy_cnt <= ram_ce_o ? busy_cnt + 1 : 0;
            if (ram_ce_o && ram_we_o)
                bench_mem[ram_addr_o[9:2]] <= (bench_mem[ram_addr_o[9:2]] & ~lane_mask(ram_sel_o))
                                              | (ram_data_o & lane_mask(ram_sel_o));
        end
    end

    // Reference model: an access granted at edge S with duration D drives the RAM
    // in cycles S..S+D-1, acks in cycle S+D, and the next grant may come at S+D+2.
    logic [31:0] model_mem [256];
    int          m_cyc = 0, m_start = 0, m_dur = 0;
    bit          m_have = 1'b0, m_last = 1'b1, m_port = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_d0 = '0, m_d1 = '0;
    logic [3:0]  m_sel = '0;

    always @(posedge clk or posedge rst) begin
        int  n;
        bit  p;
        if (rst) begin
            m_have <= 1'b0;
            m_cyc  <= 0;
            m_last <= 1'b1;
            m_d0   <= '0;
            m_d1   <= '0;
        end else begin
            n = m_cyc + 1;
            m_cyc <= n;
            if (m_have) begin
                if (n == m_start + m_dur) begin
                    if (m_we)
                        model_mem[m_addr[9:2]] <= (model_mem[m_addr[9:2]] & ~lane_mask(m_sel))
                                                  | (m_wdata & lane_mask(m_sel));
                    else if (m_port)
                        m_d1 <= model_mem[m_addr[9:2]];
                    else
                        m_d0 <= model_mem[m_addr[9:2]];
                end else if (n == m_start + m_dur + 1) begin
                    m_have <= 1'b0;
                end
            end else if (m0_ce_i || m1_ce_i) begin
                p = (m0_ce_i && m1_ce_i) ? !m_last : m1_ce_i;
                m_have  <= 1'b1;
                m_port  <= p;
                m_last  <= p;
                m_start <= n;
                m_we    <= p ? m1_we_i : m0_we_i;
                m_addr  <= p ? m1_addr_i : m0_addr_i;
                m_sel   <= p ? m1_sel_i : m0_sel_i;
                m_wdata <= p ? m1_data_i : m0_data_i;
                m_dur   <= (p ? m1_we_i : m0_we_i) ? 1 : RD_LAT;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit act, ackc;
        act  = m_have && (m_cyc < m_start + m_dur);
        ackc = m_have && (m_cyc == m_start + m_dur);
        checkOutput("ram_ce",   32'(ram_ce_o),   32'(act));
        checkOutput("ram_we",   32'(ram_we_o),   32'(act && m_we));
        checkOutput("ram_addr", ram_addr_o,      act ? m_addr : 32'h0);
        checkOutput("ram_sel",  32'(ram_sel_o),  act ? 32'(m_sel) : 32'h0);
        checkOutput("ram_data", ram_data_o,      (act && m_we) ? m_wdata : 32'h0);
        checkOutput("m0_ack",   32'(m0_ack_o),   32'(ackc && !m_port));
        checkOutput("m1_ack",   32'(m1_ack_o),   32'(ackc && m_port));
        checkOutput("m0_data",  m0_data_o,       m_d0);
        checkOutput("m1_data",  m1_data_o,       m_d1);
        checkOutput("stall",    32'(stall_o),    32'(m0_ce_i && !(ackc && !m_port)));
    end

    // Activity monitor used by the directed checks.
    int          tb_cyc = 0, ce_cnt = 0, we_cnt = 0, stall_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    int          ack_order[$];
    int          m1_ack_cyc[$];
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_sel = '0;

    always @(negedge clk) begin
        tb_cyc <= tb_cyc + 1;
        if (ram_ce_o) ce_cnt <= ce_cnt + 1;
        if (stall_o)  stall_cnt <= stall_cnt + 1;
        if (ram_we_o) begin
            we_cnt  <= we_cnt + 1;
            wr_addr <= ram_addr_o;
            wr_sel  <= ram_sel_o;
            wr_data <= ram_data_o;
        end
        if (m0_ack_o) begin
            ack0_cnt <= ack0_cnt + 1;
            ack_order.push_back(0);
        end
        if (m1_ack_o) begin
            ack1_cnt <= ack1_cnt + 1;
            ack_order.push_back(1);
            m1_ack_cyc.push_back(tb_cyc);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Issue one access and wait (bounded) for its ack; called at posedge+2.
    task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] data, input bit keep_ce);
        bit done = 1'b0;
        if (port) begin
            m1_ce_i = 1'b1; m1_we_i = we; m1_addr_i = addr; m1_sel_i = sel; m1_data_i = data;
        end else begin
            m0_ce_i = 1'b1; m0_we_i = we; m0_addr_i = addr; m0_sel_i = sel; m0_data_i = data;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #2;
            done = port ? m1_ack_o : m0_ack_o;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ack_timeout: port %0d got no ack expected ack within 20 cycles", port);
        end
        if (!keep_ce) begin
            if (port) m1_ce_i = 1'b0;
            else      m0_ce_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached expected $finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s_ce, s_we, s_stall, s_ack0, s_ack1;
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};

        for (int i = 0; i < 256; i++) begin
            bench_mem[i] = 32'hA5A50000 | 32'(i);
            model_mem[i] = 32'hA5A50000 | 32'(i);
        end
        bench_mem[4] = 32'hDEADBEEF;
        model_mem[4] = 32'hDEADBEEF;

        rst = 1'b1;
        m0_ce_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_sel_i = '0; m0_data_i = '0;
        m1_ce_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_sel_i = '0; m1_data_i = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] reset then idle");
        s_ce = ce_cnt;
        tick(10);
        checkOutput("idle_ce_cycles", 32'(ce_cnt - s_ce), 32'd0);
        checkOutput("idle_stall",     32'(stall_o),       32'd0);
        checkOutput("idle_m0_data",   m0_data_o,          32'h0);
        checkOutput("idle_ram_addr",  ram_addr_o,         32'h0);

        $display("[TB] core read");
        s_ce = ce_cnt; s_stall = stall_cnt; s_ack0 = ack0_cnt;
        applyStimulus(0, 0, 32'h10, 4'hF, 32'h0, 0);
        tick(1);
        checkOutput("rd_ce_cycles",    32'(ce_cnt - s_ce),      32'd2);
        checkOutput("rd_stall_cycles", 32'(stall_cnt - s_stall), 32'd3);
        checkOutput("rd_ack_pulses",   32'(ack0_cnt - s_ack0),  32'd1);
        checkOutput("rd_m0_data",      m0_data_o,               32'hDEADBEEF);

        $display("[TB] core write");
        s_we = we_cnt;
        applyStimulus(0, 1, 32'h20, 4'b0011, 32'h12345678, 0);
        tick(1);
        checkOutput("wr_we_cycles", 32'(we_cnt - s_we), 32'd1);
        checkOutput("wr_addr",      wr_addr,            32'h20);
        checkOutput("wr_sel",       32'(wr_sel),        32'h3);
        checkOutput("wr_data",      wr_data,            32'h12345678);
        checkOutput("wr_ram_word",  bench_mem[8],       32'hA5A55678);
        checkOutput("wr_m0_data",   m0_data_o,          32'hDEADBEEF);

        $display("[TB] hold rule on port 1");
        m1_ack_cyc.delete();
        applyStimulus(1, 0, 32'h30, 4'hF, 32'h0, 1);
        applyStimulus(1, 0, 32'h34, 4'hF, 32'h0, 0);
        tick(1);
        checkOutput("hold_acks", 32'(m1_ack_cyc.size()), 32'd2);
        if (m1_ack_cyc.size() == 2)
            checkOutput("hold_ack_gap", 32'(m1_ack_cyc[1] - m1_ack_cyc[0]), 32'd4);
        checkOutput("hold_m1_data", m1_data_o, 32'hA5A5000D);

        $display("[TB] simultaneous requests");
        tick(2);
        ack_order.delete();
        fork
            begin
                applyStimulus(0, 0, 32'h40, 4'hF, 32'h0, 1);
                applyStimulus(0, 0, 32'h44, 4'hF, 32'h0, 1);
                applyStimulus(0, 0, 32'h48, 4'hF, 32'h0, 0);
            end
            begin
                applyStimulus(1, 0, 32'h80, 4'hF, 32'h0, 1);
                applyStimulus(1, 0, 32'h84, 4'hF, 32'h0, 1);
                applyStimulus(1, 0, 32'h88, 4'hF, 32'h0, 0);
            end
        join
        tick(1);
        checkOutput("rr_count", 32'(ack_order.size()), 32'd6);
        for (int i = 0; i < 6 && i < ack_order.size(); i++)
            checkOutput("rr_order", 32'(ack_order[i]), 32'(exp_order[i]));
        checkOutput("rr_m0_data", m0_data_o, 32'hA5A50012);
        checkOutput("rr_m1_data", m1_data_o, 32'hA5A50022);

        $display("[TB] reset mid-access");
        tick(2);
        s_ack0 = ack0_cnt;
        m0_ce_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h50; m0_sel_i = 4'hF; m0_data_i = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        checkOutput("abort_busy_ce", 32'(ram_ce_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_ce", 32'(ram_ce_o), 32'd0);
        checkOutput("abort_we", 32'(ram_we_o), 32'd0);
        m0_ce_i = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(5);
        checkOutput("abort_no_ack",   32'(ack0_cnt - s_ack0), 32'd0);
        checkOutput("abort_ram_word", bench_mem[20],         32'hA5A50014);
        checkOutput("abort_m1_data",  m1_data_o,             32'h0);
        applyStimulus(0, 0, 32'h50, 4'hF, 32'h0, 0);
        tick(1);
        checkOutput("post_rst_m0_data", m0_data_o,            32'hA5A50014);
        checkOutput("post_rst_ack",     32'(ack0_cnt - s_ack0), 32'd1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
